// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, BOOT/RUN sequencer and the IF/ID pipeline register.
// Optional FETCH_ALIGN_CHECK_EN adds word alignment of redirects and a sticky misalign_err output.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr,
  output logic        if_valid
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;
  logic [31:0] pc_r;
  logic [31:0] pc_nx_s;
  logic [31:0] pc_plus4_s;
  logic [31:0] target_s;
  logic [31:0] if_pc_r;
  logic [31:0] if_pc_nx_s;
  logic [31:0] if_pc_plus4_r;
  logic [31:0] if_pc_plus4_nx_s;
  logic [31:0] if_instr_r;
  logic [31:0] if_instr_nx_s;
  logic        if_valid_r;
  logic        if_valid_nx_s;
  logic        misalign_r;
  logic        misalign_nx_s;
  logic        target_misaligned_s;

  // The memory sees the live PC so the word returns in the same cycle it is addressed.
  assign imem_addr   = pc_r;
  assign pc_plus4_s  = pc_r + 32'd4;
  assign if_pc       = if_pc_r;
  assign if_pc_plus4 = if_pc_plus4_r;
  assign if_instr    = if_instr_r;
  assign if_valid    = if_valid_r;
  assign target_misaligned_s = (redirect_target[1:0] != 2'b00);

`ifdef FETCH_ALIGN_CHECK_EN
  assign target_s     = {redirect_target[31:2], 2'b00};
  assign misalign_err = misalign_r;
`else
  // Without the checker the low bits pass through; the memory drops them when indexing.
  assign target_s     = redirect_target;
`endif

  // Next-state logic for the sequencer, PC and IF/ID register.
  always_comb begin
    state_nx_s       = state_r;
    pc_nx_s          = pc_r;
    if_pc_nx_s       = if_pc_r;
    if_pc_plus4_nx_s = if_pc_plus4_r;
    if_instr_nx_s    = if_instr_r;
    if_valid_nx_s    = if_valid_r;
    misalign_nx_s    = misalign_r;

    case (state_r)
      ST_BOOT: begin
        state_nx_s = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_valid) begin
          pc_nx_s = target_s;
        end else if (stall) begin
          pc_nx_s = pc_r;
        end else begin
          pc_nx_s = pc_plus4_s;
        end

        // A squash wins over stall so the wrong-path word never reaches decode.
        if (flush || redirect_valid) begin
          if_instr_nx_s = 32'h00000000;
          if_valid_nx_s = 1'b0;
        end else if (stall) begin
          if_valid_nx_s = if_valid_r;
        end else begin
          if_pc_nx_s       = pc_r;
          if_pc_plus4_nx_s = pc_plus4_s;
          if_instr_nx_s    = imem_instr;
          if_valid_nx_s    = 1'b1;
        end

        if (redirect_valid && target_misaligned_s) begin
          misalign_nx_s = 1'b1;
        end else begin
          misalign_nx_s = misalign_r;
        end
      end
      default: begin
        state_nx_s = ST_BOOT;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_BOOT;
      pc_r          <= RESET_PC;
      if_pc_r       <= 32'h00000000;
      if_pc_plus4_r <= 32'h00000000;
      if_instr_r    <= 32'h00000000;
      if_valid_r    <= 1'b0;
      misalign_r    <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      pc_r          <= pc_nx_s;
      if_pc_r       <= if_pc_nx_s;
      if_pc_plus4_r <= if_pc_plus4_nx_s;
      if_instr_r    <= if_instr_nx_s;
      if_valid_r    <= if_valid_nx_s;
      misalign_r    <= misalign_nx_s;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a combinational 256-word instruction memory.
// Define FETCH_ALIGN_CHECK_EN for both files to exercise the alignment checker.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        if_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  logic [31:0] mem [0:255];
  int errors;
  int checks;

  fetch_unit #(.RESET_PC(32'h00000000)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .flush(flush),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .imem_addr(imem_addr),
    .imem_instr(imem_instr),
    .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4),
    .if_instr(if_instr),
    .if_valid(if_valid)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .misalign_err(misalign_err)
`endif
  );

  assign imem_instr = mem[imem_addr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse released just after an edge; the next edge is the BOOT edge.
  task automatic do_reset();
    stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    #3;
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=%h", imem_addr, 32'h0); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", if_valid); end
    checks++; if ({if_pc, if_pc_plus4, if_instr} !== 96'h0) begin errors++; $display("FAIL reset_ifid got=%h %h %h exp=0", if_pc, if_pc_plus4, if_instr); end
`ifdef FETCH_ALIGN_CHECK_EN
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
`endif
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_boot();
    logic [31:0] exp_pc [0:3];
    logic [31:0] exp_in [0:3];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
    exp_in[0] = 32'h8C090000; exp_in[1] = 32'h212B0005; exp_in[2] = 32'hAC0B0008; exp_in[3] = 32'h0;
    tick();
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL boot_edge got valid=%b addr=%h exp valid=0 addr=0", if_valid, imem_addr); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (if_valid !== 1'b1 || if_pc !== exp_pc[i] || if_instr !== exp_in[i] || if_pc_plus4 !== exp_pc[i] + 32'd4) begin
        errors++;
        $display("FAIL boot_seq%0d got v=%b pc=%h p4=%h in=%h exp v=1 pc=%h p4=%h in=%h", i, if_valid, if_pc, if_pc_plus4, if_instr, exp_pc[i], exp_pc[i] + 32'd4, exp_in[i]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (imem_addr !== 32'h4 || if_pc !== 32'h0 || if_valid !== 1'b1 || if_instr !== 32'h8C090000) begin
        errors++;
        $display("FAIL stall_hold%0d got addr=%h pc=%h v=%b in=%h exp addr=4 pc=0 v=1 in=8c090000", i, imem_addr, if_pc, if_valid, if_instr);
      end
    end
    stall = 1'b0;
    tick();
    checks++; if (if_pc !== 32'h4 || if_instr !== 32'h212B0005 || imem_addr !== 32'h8) begin errors++; $display("FAIL stall_release got pc=%h in=%h addr=%h exp pc=4 in=212b0005 addr=8", if_pc, if_instr, imem_addr); end
  endtask

  task automatic test_redirect_stall();
    redirect_valid = 1'b1; redirect_target = 32'h20; stall = 1'b1;
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    checks++; if (imem_addr !== 32'h20 || if_valid !== 1'b0 || if_instr !== 32'h0) begin errors++; $display("FAIL redir_stall got addr=%h v=%b in=%h exp addr=20 v=0 in=0", imem_addr, if_valid, if_instr); end
    tick();
    checks++; if (if_pc !== 32'h20 || if_instr !== 32'hDEADBEEF || if_valid !== 1'b1 || if_pc_plus4 !== 32'h24) begin errors++; $display("FAIL redir_target got pc=%h in=%h v=%b p4=%h exp pc=20 in=deadbeef v=1 p4=24", if_pc, if_instr, if_valid, if_pc_plus4); end
  endtask

  task automatic test_flush();
    do_reset();
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (if_valid !== 1'b0 || if_instr !== 32'h0 || imem_addr !== 32'h8) begin errors++; $display("FAIL flush got v=%b in=%h addr=%h exp v=0 in=0 addr=8", if_valid, if_instr, imem_addr); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'hAC0B0008) begin errors++; $display("FAIL flush_after got v=%b pc=%h in=%h exp v=1 pc=8 in=ac0b0008", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_target = 32'hFFFFFFFC;
    tick();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_load got addr=%h exp fffffffc", imem_addr); end
    tick();
    checks++; if (if_pc !== 32'hFFFFFFFC || if_pc_plus4 !== 32'h0 || imem_addr !== 32'h0 || if_instr !== 32'h0BADF00D) begin errors++; $display("FAIL wrap got pc=%h p4=%h addr=%h in=%h exp pc=fffffffc p4=0 addr=0 in=0badf00d", if_pc, if_pc_plus4, imem_addr, if_instr); end
  endtask

  task automatic test_boot_ignore();
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'h40; flush = 1'b1; stall = 1'b1;
    tick();
    redirect_valid = 1'b0; flush = 1'b0; stall = 1'b0;
    checks++; if (imem_addr !== 32'h0 || if_valid !== 1'b0) begin errors++; $display("FAIL boot_ignore got addr=%h v=%b exp addr=0 v=0", imem_addr, if_valid); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h8C090000) begin errors++; $display("FAIL boot_ignore_run got v=%b pc=%h in=%h exp v=1 pc=0 in=8c090000", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL midrun_pc got addr=%h exp 10", imem_addr); end
    #2 reset = 1'b1;
    #1;
    checks++; if (imem_addr !== 32'h0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin errors++; $display("FAIL midrun_reset got addr=%h v=%b pc=%h in=%h exp all 0", imem_addr, if_valid, if_pc, if_instr); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL midrun_reboot got v=%b addr=%h exp v=0 addr=0", if_valid, imem_addr); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL midrun_restart got v=%b pc=%h exp v=1 pc=0", if_valid, if_pc); end
  endtask

  task automatic test_align();
    redirect_valid = 1'b1; redirect_target = 32'h22;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    checks++; if (imem_addr !== 32'h20 || misalign_err !== 1'b1) begin errors++; $display("FAIL align_chk got addr=%h err=%b exp addr=20 err=1", imem_addr, misalign_err); end
    tick();
    checks++; if (misalign_err !== 1'b1 || if_instr !== 32'hDEADBEEF) begin errors++; $display("FAIL align_sticky got err=%b in=%h exp err=1 in=deadbeef", misalign_err, if_instr); end
`else
    checks++; if (imem_addr !== 32'h22) begin errors++; $display("FAIL align_pass got addr=%h exp 22", imem_addr); end
    tick();
    checks++; if (if_pc !== 32'h22 || if_instr !== 32'hDEADBEEF || imem_addr !== 32'h26) begin errors++; $display("FAIL align_word got pc=%h in=%h addr=%h exp pc=22 in=deadbeef addr=26", if_pc, if_instr, imem_addr); end
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]   = 32'h8C090000;
    mem[1]   = 32'h212B0005;
    mem[2]   = 32'hAC0B0008;
    mem[8]   = 32'hDEADBEEF;
    mem[255] = 32'h0BADF00D;
    test_reset();
    test_boot();
    test_stall();
    test_redirect_stall();
    test_flush();
    test_wrap();
    test_boot_ignore();
    test_reset_midrun();
    test_align();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
